echo_detector: RTL and testbench
================================

# echo_detector

Downstream consumer of the 4-tap mean-average filter output in the sonar receive chain. After each transmit burst it measures time-of-flight by counting filtered samples until an echo clears a hysteresis threshold. While the echo lasts it tracks the peak amplitude and the echo width, then reports one result per measurement.

## Interface
- N_BITS, 32: filtered sample width, unsigned magnitude.
- CNT_BITS, 16: width of sample counters (tof, width, blank, window).
- CONFIRM, 2: consecutive above-threshold samples needed to qualify an echo (≥1).

- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse: transmit burst issued; begin a measurement.
- we  in  1  sample strobe, the same enable that advances the filter; data_in is valid when high.
- data_in  in  N_BITS  filtered magnitude (filter data_out).
- thr_hi  in  N_BITS  echo-entry threshold.
- thr_lo  in  N_BITS  echo-exit threshold (thr_lo ≤ thr_hi required by software).
- blank_len  in  CNT_BITS  samples ignored after start (transducer ringing).
- window_len  in  CNT_BITS  maximum samples per measurement; 0 means 2^CNT_BITS.
- busy  out  1  measurement in progress.
- done  out  1  one-cycle result pulse.
- echo_found  out  1  valid echo detected in last measurement.
- timed_out  out  1  last measurement ended by window expiry.
- tof  out  CNT_BITS  sample index of first qualifying sample; all-ones if none.
- peak  out  N_BITS  maximum data_in during echo; 0 if none.
- width  out  CNT_BITS  samples in echo, from first qualifying sample up to and excluding the exit sample.

## Operation
- Config inputs (thr_hi, thr_lo, blank_len, window_len) are latched on start. Changes mid-measurement have no effect.
- Sample index idx: cleared on start; increments on each we while busy. The first we after start is idx 0.
- States:
  - IDLE: busy=0. On start → BLANK, or → LISTEN if blank_len=0.
  - BLANK: on a sample with idx = blank_len−1 → LISTEN.
  - LISTEN: a sample with data_in > thr_hi (strict, unsigned) increments run; any sample ≤ thr_hi clears run. The first sample of a run records cand_tof=idx. When run reaches CONFIRM → ECHO, with tof=cand_tof, width=CONFIRM, and peak=max over the run.
  - ECHO: a sample with data_in < thr_lo (strict) → DONE. Otherwise width++ (saturating) and peak=max(peak, data_in).
  - DONE: drive done=1 for one cycle, then → IDLE.
- Window: the sample with idx = window_len−1, if not already ending the measurement, is processed and then forces → DONE with timed_out=1.
  - Expiry in BLANK or LISTEN: echo_found=0, tof=all-ones, peak=0, width=0.
  - Expiry in ECHO: echo_found=1, with tof, peak and width as accumulated.
- Result outputs update only on entry to DONE and hold until the next DONE or rst.
- start while busy aborts the current measurement (no done pulse) and restarts it.
- start and we in the same cycle: start wins and the sample is not counted.
- we is ignored in IDLE and DONE.

## Timing
- Reset: state IDLE; busy, done, echo_found, timed_out = 0; tof=all-ones; peak=0; width=0; all internal counters 0.
- busy rises the cycle after start and falls the cycle after done.
- Result latency: done and the result outputs are valid in the cycle after the edge that registers the terminating sample (exit sample or window-last sample).
- Minimum measurement, with blank_len=0 and CONFIRM=1: start, then an above-threshold sample, then an exit sample. done appears 1 cycle after the exit sample's edge.
- Gaps in we are allowed anywhere; counters advance only on we.
- rst mid-measurement returns to reset state on the next edge, with no done pulse.

## Structure
- Shared package echo_pkg: state enum (IDLE, BLANK, LISTEN, ECHO, DONE), TOF_NONE constant (all-ones, CNT_BITS), default parameter values.
- Sub-module hyst_cmp: registered-free comparator pair returning above_hi and below_lo for one sample. It is instantiated once; FSM, counters and result registers live in echo_detector.

## Test plan
- Basic echo: thr_hi=100, thr_lo=50, blank_len=3, CONFIRM=2. Stream 0,200,200,0,0,120,150,180,90,40. Expect done, echo_found=1, tof=5, peak=180, width=4, timed_out=0.
- Glitch rejection: same config. A single sample of 200 at idx 4 followed by values ≤100 until idx 7 is not an echo. A later run at idx 8–9 gives tof=8.
- Timeout in LISTEN: window_len=10 and all samples 0. Expect done one cycle after idx 9, echo_found=0, timed_out=1, tof=0xFFFF, peak=0.
- Timeout in ECHO: window_len=8 and samples 200 from idx 3 onward. Expect echo_found=1, timed_out=1, tof=3, width=5, peak=200.
- Restart and collision: start again at idx 4 of a measurement. Expect no done pulse and idx reset. start with we high in the same cycle: that sample is not counted.
- Reset mid-ECHO: assert rst for one cycle. Expect all outputs at reset values the next cycle and no done pulse. we gaps of 3 cycles between samples leave tof unchanged.

Source files
------------

// File: rtl/echo_pkg.sv
// Shared types and defaults for the sonar echo detector: FSM state
// encoding, the "no echo" time-of-flight marker and parameter defaults.
package echo_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      BLANK  = 3'd1,
      LISTEN = 3'd2,
      ECHO   = 3'd3,
      DONE   = 3'd4
   } state_t;

   localparam int DEF_N_BITS   = 32;
   localparam int DEF_CNT_BITS = 16;
   localparam int DEF_CONFIRM  = 2;

   // Reported tof when a measurement finds no echo (default counter width).
   localparam logic [DEF_CNT_BITS-1:0] TOF_NONE = '1;

endpackage

// File: rtl/echo_detector_hyst_cmp.sv
// Purely combinational comparator pair: strict entry and exit tests of one
// filtered sample against the latched hysteresis thresholds.
module hyst_cmp #(
   parameter int N_BITS = 32
) (
   input  logic [N_BITS-1:0] sample,
   input  logic [N_BITS-1:0] thr_hi,
   input  logic [N_BITS-1:0] thr_lo,
   output logic              above_hi,
   output logic              below_lo
);

   assign above_hi = (sample > thr_hi);
   assign below_lo = (sample < thr_lo);

endmodule

// File: rtl/echo_detector.sv
// Time-of-flight echo detector: counts filtered samples after a transmit
// burst, qualifies an echo with hysteresis and reports tof, peak and width.
module echo_detector
   import echo_pkg::*;
#(
   parameter int N_BITS   = DEF_N_BITS,
   parameter int CNT_BITS = DEF_CNT_BITS,
   parameter int CONFIRM  = DEF_CONFIRM
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                we,
   input  logic [N_BITS-1:0]   data_in,
   input  logic [N_BITS-1:0]   thr_hi,
   input  logic [N_BITS-1:0]   thr_lo,
   input  logic [CNT_BITS-1:0] blank_len,
   input  logic [CNT_BITS-1:0] window_len,
   output logic                busy,
   output logic                done,
   output logic                echo_found,
   output logic                timed_out,
   output logic [CNT_BITS-1:0] tof,
   output logic [N_BITS-1:0]   peak,
   output logic [CNT_BITS-1:0] width
);

   localparam int RUN_BITS = $clog2(CONFIRM + 1);
   localparam logic [CNT_BITS-1:0] TOF_ALL = '1;
   localparam logic [CNT_BITS-1:0] ONE     = CNT_BITS'(1);
   localparam logic [RUN_BITS-1:0] RUN_MAX = RUN_BITS'(CONFIRM);
   localparam logic [CNT_BITS-1:0] CONFIRM_W = CNT_BITS'(CONFIRM);

   state_t state, state_nx;

   logic [N_BITS-1:0]   hi_q, hi_nx, lo_q, lo_nx;
   logic [CNT_BITS-1:0] blank_q, blank_nx, window_q, window_nx;

   logic [CNT_BITS-1:0] idx, idx_nx;
   logic [RUN_BITS-1:0] run, run_nx;
   logic [CNT_BITS-1:0] cand, cand_nx;
   logic [N_BITS-1:0]   run_peak, run_peak_nx;

   logic [CNT_BITS-1:0] acc_tof, acc_tof_nx, acc_width, acc_width_nx;
   logic [N_BITS-1:0]   acc_peak, acc_peak_nx;

   logic                found_nx, timed_nx;
   logic [CNT_BITS-1:0] tof_nx, width_nx;
   logic [N_BITS-1:0]   peak_nx;

   logic                above_hi, below_lo;
   logic                last_sample;
   logic                fin, fin_found, fin_timed;
   logic [CNT_BITS-1:0] fin_tof, fin_width, w_inc;
   logic [N_BITS-1:0]   fin_peak, p_max;

   hyst_cmp #(.N_BITS(N_BITS)) u_cmp (
      .sample   (data_in),
      .thr_hi   (hi_q),
      .thr_lo   (lo_q),
      .above_hi (above_hi),
      .below_lo (below_lo)
   );

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   // window_len of zero wraps to all-ones, giving the full 2^CNT_BITS window
   assign last_sample = (idx == (window_q - ONE));
   assign w_inc       = (acc_width == TOF_ALL) ? acc_width : (acc_width + ONE);
   assign p_max       = (data_in > acc_peak) ? data_in : acc_peak;

   always_comb begin
      state_nx     = state;
      hi_nx        = hi_q;
      lo_nx        = lo_q;
      blank_nx     = blank_q;
      window_nx    = window_q;
      idx_nx       = idx;
      run_nx       = run;
      cand_nx      = cand;
      run_peak_nx  = run_peak;
      acc_tof_nx   = acc_tof;
      acc_peak_nx  = acc_peak;
      acc_width_nx = acc_width;
      found_nx     = echo_found;
      timed_nx     = timed_out;
      tof_nx       = tof;
      peak_nx      = peak;
      width_nx     = width;
      fin          = 1'b0;
      fin_found    = 1'b0;
      fin_timed    = 1'b0;
      fin_tof      = TOF_ALL;
      fin_peak     = '0;
      fin_width    = '0;

      if (start) begin
         hi_nx        = thr_hi;
         lo_nx        = thr_lo;
         blank_nx     = blank_len;
         window_nx    = window_len;
         idx_nx       = '0;
         run_nx       = '0;
         cand_nx      = '0;
         run_peak_nx  = '0;
         acc_tof_nx   = TOF_ALL;
         acc_peak_nx  = '0;
         acc_width_nx = '0;
         state_nx     = (blank_len == '0) ? LISTEN : BLANK;
      end else begin
         case (state)
            IDLE: ;
            BLANK: begin
               if (we) begin
                  idx_nx = idx + ONE;
                  if (last_sample) begin
                     fin       = 1'b1;
                     fin_timed = 1'b1;
                  end else if (idx == (blank_q - ONE)) begin
                     state_nx = LISTEN;
                  end
               end
            end
            LISTEN: begin
               if (we) begin
                  idx_nx = idx + ONE;
                  if (above_hi) begin
                     run_nx      = run + RUN_BITS'(1);
                     cand_nx     = (run == '0) ? idx : cand;
                     run_peak_nx = (run == '0 || data_in > run_peak) ? data_in : run_peak;
                  end else begin
                     run_nx      = '0;
                     run_peak_nx = '0;
                  end
                  // A qualified echo on the window-last sample still reports as found
                  if (above_hi && run_nx == RUN_MAX) begin
                     acc_tof_nx   = cand_nx;
                     acc_peak_nx  = run_peak_nx;
                     acc_width_nx = CONFIRM_W;
                     if (last_sample) begin
                        fin       = 1'b1;
                        fin_found = 1'b1;
                        fin_timed = 1'b1;
                        fin_tof   = cand_nx;
                        fin_peak  = run_peak_nx;
                        fin_width = CONFIRM_W;
                     end else begin
                        state_nx = ECHO;
                     end
                  end else if (last_sample) begin
                     fin       = 1'b1;
                     fin_timed = 1'b1;
                  end
               end
            end
            ECHO: begin
               if (we) begin
                  idx_nx = idx + ONE;
                  if (below_lo) begin
                     fin       = 1'b1;
                     fin_found = 1'b1;
                     fin_tof   = acc_tof;
                     fin_peak  = acc_peak;
                     fin_width = acc_width;
                  end else begin
                     acc_width_nx = w_inc;
                     acc_peak_nx  = p_max;
                     if (last_sample) begin
                        fin       = 1'b1;
                        fin_found = 1'b1;
                        fin_timed = 1'b1;
                        fin_tof   = acc_tof;
                        fin_peak  = p_max;
                        fin_width = w_inc;
                     end
                  end
               end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
         endcase

         if (fin) begin
            state_nx = DONE;
            found_nx = fin_found;
            timed_nx = fin_timed;
            tof_nx   = fin_tof;
            peak_nx  = fin_peak;
            width_nx = fin_width;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         hi_q       <= '0;
         lo_q       <= '0;
         blank_q    <= '0;
         window_q   <= '0;
         idx        <= '0;
         run        <= '0;
         cand       <= '0;
         run_peak   <= '0;
         acc_tof    <= '0;
         acc_peak   <= '0;
         acc_width  <= '0;
         echo_found <= 1'b0;
         timed_out  <= 1'b0;
         tof        <= TOF_ALL;
         peak       <= '0;
         width      <= '0;
      end else begin
         state      <= state_nx;
         hi_q       <= hi_nx;
         lo_q       <= lo_nx;
         blank_q    <= blank_nx;
         window_q   <= window_nx;
         idx        <= idx_nx;
         run        <= run_nx;
         cand       <= cand_nx;
         run_peak   <= run_peak_nx;
         acc_tof    <= acc_tof_nx;
         acc_peak   <= acc_peak_nx;
         acc_width  <= acc_width_nx;
         echo_found <= found_nx;
         timed_out  <= timed_nx;
         tof        <= tof_nx;
         peak       <= peak_nx;
         width      <= width_nx;
      end
   end

endmodule

// File: tb/tb_echo_detector.sv
// Self-checking bench for echo_detector: directed vector table, hand-written
// restart/collision/reset sequences and randomized runs against a model.
module tb_echo_detector;
   import echo_pkg::*;

   localparam int NB = 32;
   localparam int CB = 16;
   localparam int C  = 2;
   localparam int NV = 9;
   localparam int NS = 12;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          we = 1'b0;
   logic [NB-1:0] data_in = '0;
   logic [NB-1:0] thr_hi = '0;
   logic [NB-1:0] thr_lo = '0;
   logic [CB-1:0] blank_len = '0;
   logic [CB-1:0] window_len = '0;
   logic          busy, done, echo_found, timed_out;
   logic [CB-1:0] tof, width;
   logic [NB-1:0] peak;

   echo_detector #(.N_BITS(NB), .CNT_BITS(CB), .CONFIRM(C)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .we         (we),
      .data_in    (data_in),
      .thr_hi     (thr_hi),
      .thr_lo     (thr_lo),
      .blank_len  (blank_len),
      .window_len (window_len),
      .busy       (busy),
      .done       (done),
      .echo_found (echo_found),
      .timed_out  (timed_out),
      .tof        (tof),
      .peak       (peak),
      .width      (width)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned hi, lo, blank, window, n;
      int          gap;
      bit          e_done, e_found, e_timed;
      int unsigned e_tof, e_peak, e_width, e_end;
   } vec_t;

   vec_t        vecs[NV];
   int unsigned tbl_s[NV][NS];

   int n_checks = 0;
   int n_fail   = 0;

   int unsigned cfg_hi, cfg_lo, cfg_blank, cfg_window;
   logic [NB-1:0] smp[64];
   int nsmp;

   // Monitor: samples counted since start, and a snapshot of results at done
   int done_seen = 0;
   int we_cnt = 0;
   int cap_cnt;
   logic cap_found, cap_timed;
   logic [CB-1:0] cap_tof, cap_width;
   logic [NB-1:0] cap_peak;

   always @(posedge clk) begin
      if (rst || start) we_cnt <= 0;
      else if (we) we_cnt <= we_cnt + 1;
   end

   always @(negedge clk) begin
      if (done) begin
         done_seen = done_seen + 1;
         cap_cnt   = we_cnt;
         cap_found = echo_found;
         cap_timed = timed_out;
         cap_tof   = tof;
         cap_peak  = peak;
         cap_width = width;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic pulseStart(input bit with_we, input logic [NB-1:0] d);
      @(negedge clk);
      thr_hi     = cfg_hi;
      thr_lo     = cfg_lo;
      blank_len  = CB'(cfg_blank);
      window_len = CB'(cfg_window);
      start      = 1'b1;
      we         = with_we;
      data_in    = d;
      @(negedge clk);
      start = 1'b0;
      we    = 1'b0;
      // Mid-measurement config changes must not matter
      thr_hi     = $urandom;
      thr_lo     = $urandom;
      blank_len  = CB'($urandom);
      window_len = CB'($urandom);
      checkOutput("busy_rise", {31'd0, busy}, 32'd1);
   endtask

   task automatic feedSamples(input int from, input int to, input int gap);
      for (int k = from; k < to; k++) begin
         int g;
         g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
         repeat (g) @(negedge clk);
         we      = 1'b1;
         data_in = smp[k];
         @(negedge clk);
         we = 1'b0;
      end
   endtask

   task automatic checkResult(input string tag, input bit e_done, input bit e_found,
                              input bit e_timed, input int unsigned e_tof,
                              input int unsigned e_peak, input int unsigned e_width,
                              input int unsigned e_end);
      repeat (3) @(negedge clk);
      if (e_done) begin
         checkOutput({tag, ".done_count"}, done_seen, 1);
         checkOutput({tag, ".latency"}, cap_cnt, e_end);
         checkOutput({tag, ".echo_found"}, {31'd0, cap_found}, {31'd0, e_found});
         checkOutput({tag, ".timed_out"}, {31'd0, cap_timed}, {31'd0, e_timed});
         checkOutput({tag, ".tof"}, {16'd0, cap_tof}, e_tof);
         checkOutput({tag, ".peak"}, cap_peak, e_peak);
         checkOutput({tag, ".width"}, {16'd0, cap_width}, e_width);
         checkOutput({tag, ".busy_fall"}, {31'd0, busy}, 32'd0);
         checkOutput({tag, ".tof_hold"}, {16'd0, tof}, e_tof);
      end else begin
         checkOutput({tag, ".no_done"}, done_seen, 0);
         checkOutput({tag, ".still_busy"}, {31'd0, busy}, 32'd1);
      end
   endtask

   task automatic applyStimulus(input string tag, input int gap, input bit e_done,
                                input bit e_found, input bit e_timed, input int unsigned e_tof,
                                input int unsigned e_peak, input int unsigned e_width,
                                input int unsigned e_end);
      done_seen = 0;
      pulseStart(1'b0, '0);
      feedSamples(0, nsmp, gap);
      checkResult(tag, e_done, e_found, e_timed, e_tof, e_peak, e_width, e_end);
   endtask

   // Reference: scan the sample list for the first confirmed run after blanking,
   // then walk forward to the exit sample or the end of the window.
   task automatic refModel(output bit e_done, output bit e_found, output bit e_timed,
                           output int unsigned e_tof, output int unsigned e_peak,
                           output int unsigned e_width, output int unsigned e_end);
      int W, first, e;
      bit stop;
      W = (cfg_window == 0) ? 65536 : int'(cfg_window);
      e_done = 0; e_found = 0; e_timed = 0;
      e_tof = 32'hFFFF; e_peak = 0; e_width = 0; e_end = 0;
      first = -1;
      for (int i = int'(cfg_blank); (i + C - 1 < W) && (i + C - 1 < nsmp) && first < 0; i++) begin
         bit ok = 1;
         for (int k = 0; k < C; k++) if (!(smp[i+k] > cfg_hi)) ok = 0;
         if (ok) first = i;
      end
      if (first < 0) begin
         if (nsmp >= W) begin
            e_done = 1; e_timed = 1; e_end = W;
         end
      end else begin
         e_found = 1;
         e_tof = first;
         e_width = C;
         for (int k = 0; k < C; k++) if (smp[first+k] > e_peak) e_peak = smp[first+k];
         e = first + C - 1;
         if (e == W - 1) begin
            e_done = 1; e_timed = 1; e_end = W;
         end else begin
            stop = 0;
            for (int j = e + 1; j < nsmp && !stop; j++) begin
               if (smp[j] < cfg_lo) begin
                  e_done = 1; e_end = j + 1; stop = 1;
               end else begin
                  if (e_width < 65535) e_width++;
                  if (smp[j] > e_peak) e_peak = smp[j];
                  if (j == W - 1) begin
                     e_done = 1; e_timed = 1; e_end = W; stop = 1;
                  end
               end
            end
         end
      end
   endtask

   task automatic loadBasic();
      int unsigned b[10] = '{0, 200, 200, 0, 0, 120, 150, 180, 90, 40};
      cfg_hi = 100; cfg_lo = 50; cfg_blank = 3; cfg_window = 0;
      for (int k = 0; k < 10; k++) smp[k] = b[k];
      nsmp = 10;
   endtask

   initial begin
      bit rd, rf, rt;
      int unsigned rtof, rpeak, rwidth, rend;

      vecs[0] = '{100, 50, 3, 0, 10, 0, 1, 1, 0, 5, 180, 4, 10};
      tbl_s[0] = '{0, 200, 200, 0, 0, 120, 150, 180, 90, 40, 0, 0};
      vecs[1] = '{100, 50, 3, 0, 11, 0, 1, 1, 0, 8, 200, 2, 11};
      tbl_s[1] = '{0, 0, 0, 0, 200, 100, 50, 0, 200, 200, 30, 0};
      vecs[2] = '{100, 50, 3, 10, 12, 0, 1, 0, 1, 32'hFFFF, 0, 0, 10};
      tbl_s[2] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      vecs[3] = '{100, 50, 3, 8, 12, 0, 1, 1, 1, 3, 200, 5, 8};
      tbl_s[3] = '{0, 0, 0, 200, 200, 200, 200, 200, 200, 200, 200, 200};
      vecs[4] = '{100, 50, 3, 0, 10, 3, 1, 1, 0, 5, 180, 4, 10};
      tbl_s[4] = '{0, 200, 200, 0, 0, 120, 150, 180, 90, 40, 0, 0};
      vecs[5] = '{100, 50, 0, 0, 6, 0, 1, 1, 0, 2, 200, 3, 6};
      tbl_s[5] = '{150, 100, 200, 130, 50, 49, 0, 0, 0, 0, 0, 0};
      vecs[6] = '{100, 50, 5, 4, 6, 0, 1, 0, 1, 32'hFFFF, 0, 0, 4};
      tbl_s[6] = '{200, 200, 200, 200, 200, 200, 0, 0, 0, 0, 0, 0};
      vecs[7] = '{100, 50, 0, 5, 6, 0, 1, 1, 1, 3, 200, 2, 5};
      tbl_s[7] = '{0, 0, 0, 200, 200, 200, 0, 0, 0, 0, 0, 0};
      vecs[8] = '{10, 5, 1, 0, 8, 0, 1, 1, 0, 2, 90, 5, 8};
      tbl_s[8] = '{50, 3, 20, 30, 7, 90, 5, 4, 0, 0, 0, 0};

      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("reset.busy", {31'd0, busy}, 32'd0);
      checkOutput("reset.done", {31'd0, done}, 32'd0);
      checkOutput("reset.echo_found", {31'd0, echo_found}, 32'd0);
      checkOutput("reset.timed_out", {31'd0, timed_out}, 32'd0);
      checkOutput("reset.tof", {16'd0, tof}, {16'd0, TOF_NONE});
      checkOutput("reset.peak", peak, 32'd0);
      checkOutput("reset.width", {16'd0, width}, 32'd0);

      for (int v = 0; v < NV; v++) begin
         cfg_hi = vecs[v].hi; cfg_lo = vecs[v].lo;
         cfg_blank = vecs[v].blank; cfg_window = vecs[v].window;
         nsmp = int'(vecs[v].n);
         for (int k = 0; k < NS; k++) smp[k] = tbl_s[v][k];
         applyStimulus($sformatf("vec%0d", v), vecs[v].gap, vecs[v].e_done, vecs[v].e_found,
                       vecs[v].e_timed, vecs[v].e_tof, vecs[v].e_peak, vecs[v].e_width,
                       vecs[v].e_end);
      end

      // Restart at idx 4 with a run already pending
      loadBasic();
      smp[0] = 0; smp[1] = 0; smp[2] = 0; smp[3] = 200;
      done_seen = 0;
      pulseStart(1'b0, '0);
      feedSamples(0, 4, 0);
      loadBasic();
      pulseStart(1'b0, '0);
      feedSamples(0, nsmp, 0);
      checkResult("restart", 1, 1, 0, 5, 180, 4, 10);

      // start and we together: that sample is not counted
      loadBasic();
      done_seen = 0;
      pulseStart(1'b1, '0);
      feedSamples(0, nsmp, 0);
      checkResult("collision", 1, 1, 0, 5, 180, 4, 10);

      // Reset while in ECHO
      loadBasic();
      done_seen = 0;
      pulseStart(1'b0, '0);
      feedSamples(0, 8, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("rstmid.busy", {31'd0, busy}, 32'd0);
      checkOutput("rstmid.done", {31'd0, done}, 32'd0);
      checkOutput("rstmid.echo_found", {31'd0, echo_found}, 32'd0);
      checkOutput("rstmid.timed_out", {31'd0, timed_out}, 32'd0);
      checkOutput("rstmid.tof", {16'd0, tof}, 32'hFFFF);
      checkOutput("rstmid.peak", peak, 32'd0);
      checkOutput("rstmid.width", {16'd0, width}, 32'd0);
      feedSamples(8, 10, 3);
      repeat (3) @(negedge clk);
      checkOutput("rstmid.no_done", done_seen, 0);
      checkOutput("rstmid.idle", {31'd0, busy}, 32'd0);

      // Randomized measurements against the reference model
      for (int t = 0; t < 60; t++) begin
         cfg_hi = $urandom_range(50, 150);
         cfg_lo = $urandom_range(10, cfg_hi);
         cfg_blank = $urandom_range(0, 5);
         cfg_window = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 30);
         nsmp = $urandom_range(1, 40);
         for (int k = 0; k < nsmp; k++) begin
            case ($urandom_range(0, 5))
               0: smp[k] = cfg_lo - 1;
               1: smp[k] = cfg_lo;
               2: smp[k] = cfg_hi;
               3: smp[k] = cfg_hi + 1;
               default: smp[k] = $urandom_range(0, 255);
            endcase
         end
         refModel(rd, rf, rt, rtof, rpeak, rwidth, rend);
         applyStimulus($sformatf("rand%0d", t), -1, rd, rf, rt, rtof, rpeak, rwidth, rend);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
